// File: rtl/stream_mux_nto1_pkg.sv
// Shared definitions for the stream selector: mode encodings and the
// channel-index width helper used to size select/index ports.
package stream_mux_nto1_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Ceiling log2, evaluated at elaboration time only.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Channel-index width; never narrower than one bit.
    function automatic int sel_width(input int ch);
        return (clog2(ch) < 1) ? 1 : clog2(ch);
    endfunction

endpackage

// File: rtl/stream_mux_nto1_rr_priority_pick.sv
// Rotating-priority search: returns the first set request bit starting at
// ptr and wrapping modulo CHANNELS. Purely combinational, reusable by any
// arbiter that keeps its own pointer.
module rr_priority_pick
    import stream_mux_nto1_pkg::*;
#(
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = sel_width(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SEL_W-1:0]    ptr,
    output logic                found,
    output logic [SEL_W-1:0]    idx
);

    // Scan from the farthest candidate back to ptr so the nearest one wins.
    always_comb begin
        logic [SEL_W-1:0] cand;
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            cand = SEL_W'((int'(ptr) + k) % CHANNELS);
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/stream_mux_nto1.sv
// Registered N-to-1 stream selector. Merges CHANNELS valid/ready producer
// streams into one consumer stream, either from a software-fixed channel or
// by round-robin arbitration among valid channels. One output register.
//
// Handshake: a word moves on any channel (input or output side) in a cycle
// where its valid and ready are both high at the rising edge. Valid must not
// wait on ready; InReady is combinational from OutReady, InValid, Mode, Sel
// and the pointer, never from data, and at most one InReady bit is high.
module stream_mux_nto1
    import stream_mux_nto1_pkg::*;
#(
    parameter  int WIDTH    = 32,
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = sel_width(CHANNELS)
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic                      Mode,
    input  logic [SEL_W-1:0]          Sel,
    input  logic [CHANNELS*WIDTH-1:0] InData,
    input  logic [CHANNELS-1:0]       InValid,
    output logic [CHANNELS-1:0]       InReady,
    output logic [WIDTH-1:0]          OutData,
    output logic [SEL_W-1:0]          OutChan,
    output logic                      OutValid,
    input  logic                      OutReady
);

    logic                    load_en;
    logic [(1<<SEL_W)-1:0]   valid_pad;
    logic                    fixed_found;
    logic                    rr_found;
    logic [SEL_W-1:0]        rr_idx;
    logic                    grant;
    logic [SEL_W-1:0]        gidx;
    logic [WIDTH-1:0]        gword;
    logic [SEL_W-1:0]        ptr;
    logic [SEL_W-1:0]        ptr_next;

    // The output register can take a word when empty or draining this cycle.
    assign load_en = !OutValid || OutReady;

    // Zero-extended so an out-of-range Sel reads a 0 instead of off the end.
    assign valid_pad   = (1 << SEL_W)'(InValid);
    assign fixed_found = (int'(Sel) < CHANNELS) && valid_pad[Sel];

    rr_priority_pick #(
        .CHANNELS (CHANNELS)
    ) u_pick (
        .req   (InValid),
        .ptr   (ptr),
        .found (rr_found),
        .idx   (rr_idx)
    );

    // Grant select: Mode and Sel act on the grant in the cycle presented.
    always_comb begin
        grant = 1'b0;
        gidx  = '0;
        if (Mode == MODE_RR) begin
            grant = rr_found;
            gidx  = rr_idx;
        end else begin
            grant = fixed_found;
            gidx  = Sel;
        end
    end

    // InReady decode: one-hot on the granted channel, silent during reset.
    always_comb begin
        InReady = '0;
        if (load_en && grant && !Rst) begin
            InReady = CHANNELS'(1) << gidx;
        end
    end

    // Word select for the granted channel.
    always_comb begin
        gword = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (gidx == SEL_W'(i)) begin
                gword = InData[i*WIDTH +: WIDTH];
            end
        end
    end

    // Explicit wrap keeps ptr inside 0..CHANNELS-1 for non-power-of-two sizes.
    assign ptr_next = (int'(gidx) == CHANNELS - 1) ? '0 : gidx + 1'b1;

    // Output register and round-robin pointer; both freeze while stalled.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            OutData  <= '0;
            OutChan  <= '0;
            OutValid <= 1'b0;
            ptr      <= '0;
        end else if (load_en) begin
            if (grant) begin
                OutData  <= gword;
                OutChan  <= gidx;
                OutValid <= 1'b1;
                if (Mode == MODE_RR) begin
                    ptr <= ptr_next;
                end
            end else begin
                OutValid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_mux_nto1.sv
// Directed bench for stream_mux_nto1: a 4-channel instance for the main
// scenarios and a 3-channel instance for skip/wrap on a non-power-of-two size.
module tb_stream_mux_nto1;

    int n_cmp = 0;
    int n_err = 0;

    logic Clk = 1'b0;
    logic Rst = 1'b1;

    // 4-channel instance
    logic         mode4 = 1'b0;
    logic [1:0]   sel4 = 2'd0;
    logic [127:0] data4 = {32'hCAFE0003, 32'hCAFE0002, 32'hCAFE0001, 32'hCAFE0000};
    logic [3:0]   valid4 = 4'h0;
    logic [3:0]   ready4;
    logic [31:0]  odata4;
    logic [1:0]   ochan4;
    logic         ovalid4;
    logic         oready4 = 1'b1;

    // 3-channel instance
    logic         mode3 = 1'b0;
    logic [1:0]   sel3 = 2'd0;
    logic [95:0]  data3 = {32'h000000B2, 32'h000000B1, 32'h000000B0};
    logic [2:0]   valid3 = 3'h0;
    logic [2:0]   ready3;
    logic [31:0]  odata3;
    logic [1:0]   ochan3;
    logic         ovalid3;
    logic         oready3 = 1'b1;

    always #5 Clk = ~Clk;

    stream_mux_nto1 #(.WIDTH(32), .CHANNELS(4)) dut4 (
        .Clk (Clk), .Rst (Rst), .Mode (mode4), .Sel (sel4),
        .InData (data4), .InValid (valid4), .InReady (ready4),
        .OutData (odata4), .OutChan (ochan4), .OutValid (ovalid4),
        .OutReady (oready4)
    );

    stream_mux_nto1 #(.WIDTH(32), .CHANNELS(3)) dut3 (
        .Clk (Clk), .Rst (Rst), .Mode (mode3), .Sel (sel3),
        .InData (data3), .InValid (valid3), .InReady (ready3),
        .OutData (odata3), .OutChan (ochan3), .OutValid (ovalid3),
        .OutReady (oready3)
    );

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset held 3 cycles with every channel valid
        Rst = 1'b1;
        valid4 = 4'hF;
        valid3 = 3'h7;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("rst_inready4", 32'(ready4), 32'h0);
            chk("rst_inready3", 32'(ready3), 32'h0);
            tick();
            chk("rst_outvalid4", 32'(ovalid4), 32'h0);
        end
        Rst = 1'b0;
        valid4 = 4'h0;
        valid3 = 3'h0;
        settle();
        chk("rst_outdata4", odata4, 32'h0);
        chk("rst_outchan4", 32'(ochan4), 32'h0);
        chk("rst_outvalid4_rel", 32'(ovalid4), 32'h0);

        // Fixed mode, Sel=2, channels 0 and 2 valid: only channel 2 granted
        mode4 = 1'b0;
        sel4 = 2'd2;
        valid4 = 4'b0101;
        settle();
        chk("fix_inready", 32'(ready4), 32'h4);
        tick();
        chk("fix_outdata", odata4, 32'hCAFE0002);
        chk("fix_outchan", 32'(ochan4), 32'h2);
        chk("fix_outvalid", 32'(ovalid4), 32'h1);

        // Sel=3 with channel 3 idle: no grant, output drains
        sel4 = 2'd3;
        settle();
        chk("fix_nogrant_ready", 32'(ready4), 32'h0);
        tick();
        chk("fix_nogrant_valid", 32'(ovalid4), 32'h0);
        chk("fix_nogrant_hold", odata4, 32'hCAFE0002);

        // Round-robin, all valid: 0,1,2,3,0,1,2,3 with no bubbles
        mode4 = 1'b1;
        valid4 = 4'hF;
        for (int i = 0; i < 8; i++) begin
            settle();
            chk("rr_inready", 32'(ready4), 32'(1 << (i % 4)));
            tick();
            chk("rr_outchan", 32'(ochan4), 32'(i % 4));
            chk("rr_outdata", odata4, 32'hCAFE0000 + 32'(i % 4));
            chk("rr_outvalid", 32'(ovalid4), 32'h1);
        end

        // Load 32'h11 from channel 0 in fixed mode (pointer stays at 0)
        mode4 = 1'b0;
        sel4 = 2'd0;
        data4[31:0] = 32'h00000011;
        data4[63:32] = 32'h00000022;
        valid4 = 4'b0001;
        tick();
        chk("bp_load", odata4, 32'h11);

        // Stall 4 cycles in round-robin with channel 1 valid
        mode4 = 1'b1;
        valid4 = 4'b0010;
        oready4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("bp_inready", 32'(ready4), 32'h0);
            tick();
            chk("bp_outdata", odata4, 32'h11);
            chk("bp_outchan", 32'(ochan4), 32'h0);
            chk("bp_outvalid", 32'(ovalid4), 32'h1);
        end

        // Release: same-cycle replacement by channel 1's word
        oready4 = 1'b1;
        settle();
        chk("bp_release_ready", 32'(ready4), 32'h2);
        tick();
        chk("bp_replace_data", odata4, 32'h22);
        chk("bp_replace_chan", 32'(ochan4), 32'h1);
        chk("bp_replace_valid", 32'(ovalid4), 32'h1);

        // Pointer now 2; a channel-2 transfer moves it to 3
        valid4 = 4'b0100;
        settle();
        chk("ms_pre_ready", 32'(ready4), 32'h4);
        tick();
        chk("ms_pre_chan", 32'(ochan4), 32'h2);

        // Fixed Sel=0 for two transfers; pointer must survive
        mode4 = 1'b0;
        sel4 = 2'd0;
        valid4 = 4'hF;
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("ms_fix_ready", 32'(ready4), 32'h1);
            tick();
            chk("ms_fix_chan", 32'(ochan4), 32'h0);
        end

        // Back to round-robin: resumes at channel 3, then wraps to 0
        mode4 = 1'b1;
        settle();
        chk("ms_rr_ready", 32'(ready4), 32'h8);
        tick();
        chk("ms_rr_chan3", 32'(ochan4), 32'h3);
        tick();
        chk("ms_rr_chan0", 32'(ochan4), 32'h0);

        // Reset while stalled discards the held word
        oready4 = 1'b0;
        settle();
        chk("midrst_stall_ready", 32'(ready4), 32'h0);
        Rst = 1'b1;
        oready4 = 1'b1;
        settle();
        chk("midrst_inready", 32'(ready4), 32'h0);
        tick();
        chk("midrst_valid", 32'(ovalid4), 32'h0);
        chk("midrst_data", odata4, 32'h0);
        chk("midrst_chan", 32'(ochan4), 32'h0);
        Rst = 1'b0;

        // 3-channel: move pointer to 1 via a channel-0 transfer
        mode3 = 1'b1;
        valid3 = 3'b001;
        settle();
        chk("c3_ready0", 32'(ready3), 32'h1);
        tick();
        chk("c3_chan0", 32'(ochan3), 32'h0);
        chk("c3_data0", odata3, 32'hB0);

        // Channels 0 and 2 valid from pointer 1: 2, 0, 2
        valid3 = 3'b101;
        settle();
        chk("c3_skip_ready", 32'(ready3), 32'h4);
        tick();
        chk("c3_skip_chan", 32'(ochan3), 32'h2);
        chk("c3_skip_data", odata3, 32'hB2);
        settle();
        chk("c3_wrap_ready", 32'(ready3), 32'h1);
        tick();
        chk("c3_wrap_chan", 32'(ochan3), 32'h0);
        settle();
        chk("c3_again_ready", 32'(ready3), 32'h4);
        tick();
        chk("c3_again_chan", 32'(ochan3), 32'h2);

        // All valid: pointer wrapped 2 -> 0, so channel 0 wins
        valid3 = 3'b111;
        settle();
        chk("c3_ptr0_ready", 32'(ready3), 32'h1);
        tick();
        chk("c3_ptr0_chan", 32'(ochan3), 32'h0);

        // Fixed Sel=3 is out of range for 3 channels: no grant
        mode3 = 1'b0;
        sel3 = 2'd3;
        settle();
        chk("c3_badsel_ready", 32'(ready3), 32'h0);
        tick();
        chk("c3_badsel_valid", 32'(ovalid3), 32'h0);
        sel3 = 2'd1;
        settle();
        chk("c3_sel1_ready", 32'(ready3), 32'h2);
        tick();
        chk("c3_sel1_data", odata3, 32'hB1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
